gsim_sweep_ctrl: RTL and testbench

- Sequencing controller for the 16-unknown Gauss-Seidel solver core.
- Accepts the 16 b-vector words over a valid/ready stream and writes them into the core's transposed storage.
- Issues one sweep command per iteration. Ends iteration on convergence (core-reported max delta <= TOL) or on MAX_ITER.
- Drains the 16 x results through a backpressured output port.

---
 rtl/gsim_sweep_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_gsim_sweep_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_sweep_ctrl.sv
// gsim_sweep_ctrl - sequencing controller for the 16-unknown Gauss-Seidel core.
//
// Loads the 16-word b vector from a valid/ready stream into the core's
// transposed storage, issues one sweep command per iteration until the core
// reports convergence (max delta <= TOL after at least N_ITER_MIN sweeps),
// the sweep cap N_ITER_MAX is reached, or the per-sweep watchdog fires, then
// drains the 16 x results through a backpressured output port.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-low reset
//   in_en/in_ready/b_in   b-vector input stream, logical order b0..b15
//   core_ld_*             registered write strobe/address/data into the core
//   core_sweep_start      one-cycle sweep command
//   core_sweep_done       one-cycle sweep completion, core_delta valid with it
//   core_rd_addr/data     combinational read port of the core
//   out_valid/ready,x_out result stream, logical order x0..x15
//   busy                  solve or drain in progress
//   converged, timeout    termination cause, held until the next load
//   iter_count            sweeps completed in the current/last solve
module gsim_sweep_ctrl #(
  parameter int unsigned N_ITER_MAX = 100,
  parameter int unsigned N_ITER_MIN = 2,
  parameter logic [31:0] TOL        = 32'h0000_0010,
  parameter int unsigned WDOG       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  output logic        in_ready,
  input  logic [15:0] b_in,
  output logic        core_ld_en,
  output logic [3:0]  core_ld_addr,
  output logic [15:0] core_ld_data,
  output logic        core_sweep_start,
  input  logic        core_sweep_done,
  input  logic [31:0] core_delta,
  output logic [3:0]  core_rd_addr,
  input  logic [31:0] core_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic        busy,
  output logic        converged,
  output logic        timeout,
  output logic [9:0]  iter_count
);

  localparam int unsigned WDW  = $clog2(WDOG + 1);
  localparam logic [9:0]  IMAX = 10'(N_ITER_MAX);
  localparam logic [9:0]  IMIN = 10'(N_ITER_MIN);
  localparam logic [WDW-1:0] WLAST = WDW'(WDOG - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Logical index k lives at physical {k[1:0],k[3:2]} (transposed storage).
  function automatic logic [3:0] phys(input logic [3:0] k);
    return {k[1:0], k[3:2]};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [3:0]     j_q, j_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic [9:0]     iter_q, iter_d, iter_next;
  logic           conv_q, conv_d;
  logic           tmo_q, tmo_d;
  logic           ld_en_q, ld_en_d;
  logic [3:0]     ld_addr_q, ld_addr_d;
  logic [15:0]    ld_data_q, ld_data_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= LOAD;
      k_q       <= '0;
      j_q       <= '0;
      wdog_q    <= '0;
      iter_q    <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ld_en_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      wdog_q    <= wdog_d;
      iter_q    <= iter_d;
      conv_q    <= conv_d;
      tmo_q     <= tmo_d;
      ld_en_q   <= ld_en_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    j_d       = j_q;
    wdog_d    = wdog_q;
    iter_d    = iter_q;
    conv_d    = conv_q;
    tmo_d     = tmo_q;
    ld_en_d   = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    iter_next = iter_q + 10'd1;

    unique case (state_q)
      LOAD: begin
        if (in_en) begin
          ld_en_d   = 1'b1;
          ld_addr_d = phys(k_q);
          ld_data_d = b_in;
          // The first beat of a solve retires the previous solve's status.
          if (k_q == 4'd0) begin
            conv_d = 1'b0;
            tmo_d  = 1'b0;
            iter_d = '0;
          end
          if (k_q == 4'd15) begin
            k_d     = '0;
            state_d = START;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end

      START: begin
        wdog_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (core_sweep_done) begin
          if (iter_q < IMAX) begin
            iter_d = iter_next;
          end
          // Convergence is tested first so it wins when it meets the cap.
          if (iter_next >= IMIN && core_delta <= TOL) begin
            conv_d  = 1'b1;
            state_d = DRAIN;
          end else if (iter_next >= IMAX) begin
            state_d = DRAIN;
          end else begin
            state_d = START;
          end
        end else if (wdog_q == WLAST) begin
          tmo_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end

      DRAIN: begin
        if (out_ready) begin
          if (j_q == 4'd15) begin
            j_d     = '0;
            state_d = LOAD;
          end else begin
            j_d = j_q + 4'd1;
          end
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // Every output is gated by reset so the port is quiet for as long as reset
  // is held low, not just from the first clock edge of the reset.
  always_comb begin
    in_ready         = reset && (state_q == LOAD);
    core_sweep_start = reset && (state_q == START);
    out_valid        = reset && (state_q == DRAIN);
    busy             = reset && (state_q != LOAD);
    core_ld_en       = reset && ld_en_q;
    core_ld_addr     = reset ? ld_addr_q : '0;
    core_ld_data     = reset ? ld_data_q : '0;
    core_rd_addr     = reset ? phys(j_q) : '0;
    x_out            = out_valid ? core_rd_data : '0;
    converged        = reset && conv_q;
    timeout          = reset && tmo_q;
    iter_count       = reset ? iter_q : '0;
  end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
module tb_gsim_sweep_ctrl;

  localparam int NMAX = 100;
  localparam int NMIN = 2;
  localparam int WDOG = 64;
  localparam logic [31:0] TOL = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_en = 1'b0;
  logic        in_ready;
  logic [15:0] b_in = '0;
  logic        core_ld_en;
  logic [3:0]  core_ld_addr;
  logic [15:0] core_ld_data;
  logic        core_sweep_start;
  logic        core_sweep_done = 1'b0;
  logic [31:0] core_delta = '0;
  logic [3:0]  core_rd_addr;
  logic [31:0] core_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] x_out;
  logic        busy;
  logic        converged;
  logic        timeout;
  logic [9:0]  iter_count;

  gsim_sweep_ctrl #(
    .N_ITER_MAX(NMAX),
    .N_ITER_MIN(NMIN),
    .TOL(TOL),
    .WDOG(WDOG)
  ) dut (
    .clk(clk), .reset(reset),
    .in_en(in_en), .in_ready(in_ready), .b_in(b_in),
    .core_ld_en(core_ld_en), .core_ld_addr(core_ld_addr), .core_ld_data(core_ld_data),
    .core_sweep_start(core_sweep_start), .core_sweep_done(core_sweep_done),
    .core_delta(core_delta),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .busy(busy), .converged(converged), .timeout(timeout), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    bit conv;
    bit to;
  } res_t;

  res_t        q_res[$];
  logic [19:0] q_w[$];
  logic [31:0] q_x[$];
  logic [3:0]  q_a[$];

  logic [31:0] tab[NMAX];
  logic [15:0] b_vals[16];
  logic [15:0] mem[16];
  bit          hang = 0;
  int          fixed_lat = 0;
  bit          pat_mode = 0;

  function automatic int map_idx(input int k);
    return (k % 4) * 4 + k / 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: storage, combinational read, sweep latency and delta script.
  assign core_rd_data = 32'hA000_0000 | ({16'h0, mem[core_rd_addr]} << 8) | {28'h0, core_rd_addr};

  int cnt = 0;
  int sidx = 0;
  always @(negedge clk) begin
    core_sweep_done = 1'b0;
    core_delta      = $urandom;
    if (!reset) begin
      cnt  = 0;
      sidx = 0;
    end else begin
      if (core_ld_en) begin
        mem[core_ld_addr] = core_ld_data;
        sidx = 0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_sweep_done = 1'b1;
          core_delta      = tab[sidx-1];
        end
      end else if (in_ready && ($urandom % 8 == 0)) begin
        core_sweep_done = 1'b1;
        core_delta      = '0;
      end
      if (core_sweep_start) begin
        sidx++;
        if (!hang) cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8));
      end
    end
  end

  int rpat = 0;
  always @(negedge clk) begin
    rpat++;
    out_ready = pat_mode ? (rpat % 3 == 0) : ($urandom % 3 != 0);
  end

  // Monitor: pops expectations whenever the DUT presents a write, a result
  // status (first DRAIN cycle) or an output word.
  int cyc = 0, wcnt = 0, starts = 0, rx = 0, last_start = 0;
  bit prev_valid = 0, chk_rdy = 0;
  always @(negedge clk) begin
    res_t r;
    logic [19:0] w;
    cyc++;
    if (!reset) begin
      wcnt = 0; starts = 0; rx = 0; prev_valid = 0; chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("ready_after_drain", {63'h0, in_ready}, 64'h1);
        chk_rdy = 0;
      end
      chk("busy_vs_ready", {63'h0, busy}, {63'h0, !in_ready});
      if (core_ld_en) begin
        if (q_w.size() == 0) begin
          chk("unexpected_write", 64'h1, 64'h0);
        end else begin
          w = q_w.pop_front();
          chk("ld_write", {44'h0, core_ld_addr, core_ld_data}, {44'h0, w});
        end
        wcnt++;
        if (wcnt == 1) chk("flags_clear", {52'h0, converged, timeout, iter_count}, 64'h0);
      end
      if (core_sweep_start) begin
        chk("start_gate", 64'(wcnt), 64'd16);
        starts++;
        last_start = cyc;
      end
      if (out_valid) begin
        if (!prev_valid) begin
          if (q_res.size() == 0) begin
            chk("unexpected_drain", 64'h1, 64'h0);
          end else begin
            r = q_res.pop_front();
            chk("iter_count", {54'h0, iter_count}, 64'(r.n));
            chk("converged", {63'h0, converged}, {63'h0, r.conv});
            chk("timeout", {63'h0, timeout}, {63'h0, r.to});
            chk("sweep_starts", 64'(starts), r.to ? 64'd1 : 64'(r.n));
            if (r.to) chk("wdog_cycles", 64'(cyc - last_start), 64'(WDOG + 1));
          end
          wcnt = 0;
          starts = 0;
        end
        if (q_x.size() == 0) begin
          chk("unexpected_xout", 64'h1, 64'h0);
        end else begin
          chk("x_out", {32'h0, x_out}, {32'h0, q_x[0]});
          chk("rd_addr", {60'h0, core_rd_addr}, {60'h0, q_a[0]});
          if (out_ready) begin
            void'(q_x.pop_front());
            void'(q_a.pop_front());
            rx++;
            if (rx == 16) begin
              rx = 0;
              chk_rdy = 1;
            end
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Reference: sweeps run until delta<=TOL (from NMIN on) or NMAX sweeps.
  task automatic prepare(input int mode, input bit fixed_b);
    res_t r;
    for (int i = 0; i < NMAX; i++) begin
      case (mode)
        0: tab[i] = (i == 0) ? 32'h100 : (i == 1) ? 32'h40 : (i == 2) ? 32'h08 : 32'h1000;
        1: tab[i] = 32'h1000;
        2: tab[i] = 32'h0;
        4: tab[i] = ($urandom % 4 == 0) ? $urandom_range(0, TOL + 1) : $urandom;
        5: tab[i] = (i == NMAX - 1) ? TOL : TOL + 1;
        6: tab[i] = (i == 0) ? 32'h0 : (i == 1) ? TOL : 32'hFFFF_FFFF;
        default: tab[i] = 32'h1000;
      endcase
    end
    hang = (mode == 3);
    r.n = 0; r.conv = 0; r.to = hang;
    if (!hang) begin
      for (int n = 1; n <= NMAX; n++) begin
        r.n = n;
        if (n >= NMIN && tab[n-1] <= TOL) begin
          r.conv = 1;
          break;
        end
      end
    end
    q_res.push_back(r);
    for (int j = 0; j < 16; j++) begin
      b_vals[j] = fixed_b ? 16'(j + 1) : 16'($urandom);
      q_x.push_back(32'hA000_0000 | (32'(b_vals[j]) << 8) | 32'(map_idx(j)));
      q_a.push_back(4'(map_idx(j)));
    end
  endtask

  task automatic load_b(input bit held);
    int k = 0, t = 0;
    bit en;
    while (k < 16 && t < 2000) begin
      en = held ? 1'b1 : ($urandom % 4 != 0);
      in_en = en;
      b_in  = en ? b_vals[k] : 16'($urandom);
      if (en && in_ready) begin
        q_w.push_back({4'(map_idx(k)), b_vals[k]});
        k++;
      end
      @(negedge clk);
      t++;
    end
    in_en = 1'b0;
    if (k < 16) chk("load_budget", 64'(k), 64'd16);
  endtask

  task automatic drain_wait();
    int t = 0;
    while (!(q_x.size() == 0 && in_ready)) begin
      in_en = $urandom % 2;
      b_in  = 16'($urandom);
      @(negedge clk);
      t++;
      if (t > 20000) begin
        chk("drain_budget", 64'(t), 64'd0);
        break;
      end
    end
    in_en = 1'b0;
  endtask

  task automatic do_solve(input int mode, input bit held, input bit fixed_b, input bit pat);
    pat_mode = pat;
    prepare(mode, fixed_b);
    load_b(held);
    drain_wait();
  endtask

  initial begin
    int s, t;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {23'h0, in_ready, core_ld_en, core_ld_addr, core_sweep_start, core_rd_addr,
                       out_valid, busy, converged, timeout, iter_count, core_ld_data}, 64'h0);
    chk("reset_xout", {32'h0, x_out}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {52'h0, in_ready, busy, iter_count}, {52'h0, 1'b1, 1'b0, 10'h0});

    do_solve(0, 1, 1, 1);
    do_solve(1, 0, 0, 0);
    do_solve(2, 0, 0, 0);
    do_solve(5, 0, 0, 0);
    do_solve(6, 1, 0, 0);
    do_solve(3, 0, 0, 1);
    do_solve(4, 1, 0, 0);

    // Reset during WAIT of sweep 5.
    fixed_lat = 6;
    pat_mode = 0;
    prepare(1, 0);
    load_b(0);
    s = 0; t = 0;
    while (s < 5 && t < 5000) begin
      if (core_sweep_start) s++;
      if (s < 5) begin
        @(negedge clk);
        t++;
      end
    end
    chk("reach_sweep5", 64'(s), 64'd5);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_res.delete();
    q_x.delete();
    q_a.delete();
    @(negedge clk);
    chk("midsolve_reset_ctrl", {23'h0, in_ready, core_ld_en, core_ld_addr, core_sweep_start, core_rd_addr,
                                out_valid, busy, converged, timeout, iter_count, core_ld_data}, 64'h0);
    chk("midsolve_reset_xout", {32'h0, x_out}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("midsolve_release", {53'h0, in_ready, iter_count}, {53'h0, 1'b1, 10'h0});
    repeat (20) @(negedge clk);
    fixed_lat = 0;

    for (int i = 0; i < 6; i++) do_solve((i % 2 == 0) ? 4 : int'($urandom_range(0, 6)), i[0], 0, 0);

    repeat (5) @(negedge clk);
    chk("queues_empty", 64'(q_res.size() + q_w.size() + q_x.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule
